// File: rtl/uart_fifo_tx_if.sv
// FIFO read-port bundle between the TX byte FIFO (master) and the UART serializer (slave).
interface uart_fifo_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;

    modport master (output fifo_empty, output fifo_dout, input fifo_rd_en);
    modport slave  (input fifo_empty, input fifo_dout, output fifo_rd_en);
endinterface

// File: rtl/uart_fifo_tx.sv
// Pops bytes from a registered-output FIFO and sends each as a UART frame (8N1 by default).
// Define UART_FIFO_TX_PARITY_EN to insert an even-parity symbol between data and stop.
module uart_fifo_tx #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int DATA_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    uart_fifo_tx_if.slave fifo,
    output logic          serial_out,
    output logic          busy
);
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_WIDTH        = $clog2(SYMBOL_EDGE_TIME);
    localparam int IDX_WIDTH        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(SYMBOL_EDGE_TIME - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
`ifdef UART_FIFO_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e                state_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic [IDX_WIDTH-1:0]  idx_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  serial_out_q;
`ifdef UART_FIFO_TX_PARITY_EN
    logic                  parity_q;
`endif

    logic pop;
    logic sym_end;
    logic in_symbol;

    // NOTE: the pop is gated by rst so a reset cycle can never consume a FIFO entry,
    // even though the state register only returns to IDLE on the clock edge.
    assign pop       = rst && en && !fifo.fifo_empty && (state_q == IDLE);
    assign sym_end   = (cnt_q == CNT_LAST);
    assign in_symbol = (state_q != IDLE) && (state_q != LOAD);

    assign fifo.fifo_rd_en = pop;
    assign busy            = (state_q != IDLE) || pop;
    assign serial_out      = serial_out_q;

    // serial_out_q is loaded at each symbol boundary with the level of the symbol that
    // follows, so the line changes only on clock edges and each symbol lasts exactly
    // SYMBOL_EDGE_TIME cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: all state, including the shift register, is cleared so an abandoned
            // frame leaves nothing behind for the next one.
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            serial_out_q <= 1'b1;
`ifdef UART_FIFO_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below sees the
            // register values from before this edge.
            if (in_symbol) begin
                cnt_q <= sym_end ? '0 : cnt_q + 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    shift_q      <= fifo.fifo_dout;
`ifdef UART_FIFO_TX_PARITY_EN
                    parity_q     <= ^fifo.fifo_dout;
`endif
                    cnt_q        <= '0;
                    idx_q        <= '0;
                    serial_out_q <= 1'b0;
                    state_q      <= START;
                end
                START: begin
                    if (sym_end) begin
                        serial_out_q <= shift_q[0];
                        state_q      <= DATA;
                    end
                end
                DATA: begin
                    if (sym_end) begin
                        if (idx_q == IDX_LAST) begin
`ifdef UART_FIFO_TX_PARITY_EN
                            serial_out_q <= parity_q;
                            state_q      <= PARITY;
`else
                            serial_out_q <= 1'b1;
                            state_q      <= STOP;
`endif
                        end else begin
                            idx_q        <= idx_q + 1'b1;
                            shift_q      <= shift_q >> 1;
                            serial_out_q <= shift_q[1];
                        end
                    end
                end
`ifdef UART_FIFO_TX_PARITY_EN
                PARITY: begin
                    if (sym_end) begin
                        serial_out_q <= 1'b1;
                        state_q      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (sym_end) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    serial_out_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_fifo_tx.sv
// Scoreboard bench for uart_fifo_tx: a FIFO model feeds the DUT, a line decoder checks
// every frame against the expected symbol sequence of each queued byte.
`timescale 1ns/1ps
module tb_uart_fifo_tx;
    localparam int CLOCK_FREQ = 1000;
    localparam int BAUD_RATE  = 100;
    localparam int DATA_WIDTH = 8;
    localparam int SET        = CLOCK_FREQ / BAUD_RATE;
`ifdef UART_FIFO_TX_PARITY_EN
    localparam int NSYM = DATA_WIDTH + 3;
`else
    localparam int NSYM = DATA_WIDTH + 2;
`endif
    localparam int FRAME = NSYM * SET;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic serial_out;
    logic busy;

    uart_fifo_tx_if #(.DATA_WIDTH(DATA_WIDTH)) fifo_if ();

    uart_fifo_tx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD_RATE (BAUD_RATE),
        .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .fifo      (fifo_if),
        .serial_out(serial_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model state: FIFO contents and the bytes expected on the line.
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    int cyc = 0;
    int n_pops = 0;
    int n_pushed = 0;
    int frames_done = 0;
    int aborted = 0;
    int last_end_cyc = -1;
    int last_gap = -1;
    int busy_run = 0;
    int last_busy_run = 0;

    // Expected line level for symbol s of the frame carrying byte b.
    function automatic logic sym_bit(input logic [7:0] b, input int s);
        if (s == 0) return 1'b0;
        if (s <= DATA_WIDTH) return b[s-1];
`ifdef UART_FIFO_TX_PARITY_EN
        if (s == DATA_WIDTH + 1) return ^b;
`endif
        return 1'b1;
    endfunction

    // FIFO with registered read data: dout is updated just after the edge that saw rd_en.
    bit fm_popped;
    bit fm_empty_at_pop;
    initial begin : fifo_model
        fifo_if.fifo_empty = 1'b1;
        fifo_if.fifo_dout  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            fm_popped       = fifo_if.fifo_rd_en;
            fm_empty_at_pop = fifo_if.fifo_empty;
            if (fm_popped) begin
                n_pops++;
                check("pop_while_empty", fm_empty_at_pop, 0);
            end
            #1;
            if (fm_popped && fifo_q.size() != 0) fifo_if.fifo_dout = fifo_q.pop_front();
            fifo_if.fifo_empty = (fifo_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_run++;
        end else begin
            if (busy_run != 0) last_busy_run = busy_run;
            busy_run = 0;
        end
    end

    // Line decoder / scoreboard monitor.
    logic       mon_line [FRAME];
    logic       mon_prev;
    logic [7:0] mon_exp;
    logic [7:0] mon_dec;
    int         mon_start;
    int         mon_bad;
    bit         mon_abort;
    bit         mon_have;
    initial begin : decoder
        mon_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && mon_prev === 1'b1 && serial_out === 1'b0) begin
                mon_start   = cyc;
                mon_abort   = 1'b0;
                mon_line[0] = serial_out;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (!rst) begin
                        mon_abort = 1'b1;
                        break;
                    end
                    mon_line[k] = serial_out;
                end
                if (mon_abort) begin
                    aborted++;
                    if (exp_q.size() != 0) mon_exp = exp_q.pop_front();
                end else begin
                    if (last_end_cyc >= 0) last_gap = mon_start - last_end_cyc - 1;
                    last_end_cyc = cyc;
                    mon_have = (exp_q.size() != 0);
                    check("frame_expected", mon_have, 1);
                    if (mon_have) begin
                        mon_exp = exp_q.pop_front();
                        mon_bad = 0;
                        for (int k = 0; k < FRAME; k++)
                            if (mon_line[k] !== sym_bit(mon_exp, k / SET)) mon_bad++;
                        check($sformatf("frame_wave_%02h_bad_cycles", mon_exp), mon_bad, 0);
                        for (int i = 0; i < DATA_WIDTH; i++)
                            mon_dec[i] = mon_line[(1 + i) * SET + SET / 2];
                        check("decoded_byte", mon_dec, mon_exp);
`ifdef UART_FIFO_TX_PARITY_EN
                        check("parity_symbol", mon_line[(DATA_WIDTH + 1) * SET + SET / 2], ^mon_exp);
`endif
                        frames_done++;
                    end
                end
            end
            mon_prev = serial_out;
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        n_pushed++;
        fifo_if.fifo_empty = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((busy !== 1'b0 || fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain_timeout"}, (busy === 1'b0 && exp_q.size() == 0), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_start(input int budget, input string name);
        int n = 0;
        while (serial_out !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({name, "_start_timeout"}, (serial_out === 1'b0), 1);
    endtask

    int p0;
    int bad;
    int n;
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_serial_out", serial_out, 1);
        check("reset_busy", busy, 0);
        check("reset_rd_en", fifo_if.fifo_rd_en, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_serial_out", serial_out, 1);
        check("post_reset_busy", busy, 0);

        // Single 0x55 frame.
        en = 1'b1;
        p0 = n_pops;
        push(8'h55);
        wait_idle(FRAME * 3, "single");
        check("single_pops", n_pops - p0, 1);
        check("single_busy_cycles", last_busy_run, FRAME + 2);
        check("single_frames", frames_done, 1);

        // Back-to-back frames.
        p0 = n_pops;
        push(8'hA3);
        push(8'h0F);
        wait_idle(FRAME * 4, "b2b");
        check("b2b_pops", n_pops - p0, 2);
        check("b2b_idle_gap", last_gap, 2);

        // Empty FIFO for 500 cycles.
        bad = 0;
        p0 = n_pops;
        repeat (500) begin
            @(negedge clk);
            if (fifo_if.fifo_rd_en !== 1'b0 || serial_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("empty_idle_bad_cycles", bad, 0);
        check("empty_pops", n_pops - p0, 0);

        // en dropped mid-frame with three bytes queued.
        p0 = n_pops;
        push(8'hFF);
        push(8'h11);
        push(8'h22);
        wait_start(50, "en_drop");
        repeat (30) @(negedge clk);
        en = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < FRAME * 2) begin
            @(negedge clk);
            n++;
        end
        check("en_drop_frame_end", busy, 0);
        bad = 0;
        repeat (300) begin
            @(negedge clk);
            if (fifo_if.fifo_rd_en !== 1'b0 || serial_out !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("en_low_bad_cycles", bad, 0);
        check("en_low_pops", n_pops - p0, 1);
        check("en_low_frames_decoded", frames_done, 4);
        en = 1'b1;
        n = 0;
        while (serial_out !== 1'b0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("en_resume_start_latency", n, 2);
        wait_idle(FRAME * 4, "en_resume");
        check("en_resume_pops", n_pops - p0, 3);

        // Reset during data bit 4.
        p0 = n_pops;
        push(8'h3C);
        push(8'hC5);
        wait_start(50, "mid_reset");
        repeat ((1 + 4) * SET + 4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_reset_serial_out", serial_out, 1);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_rd_en", fifo_if.fifo_rd_en, 0);
        rst = 1'b1;
        wait_idle(FRAME * 3, "mid_reset");
        check("mid_reset_aborted", aborted, 1);
        check("mid_reset_pops", n_pops - p0, 2);

        // 0x07 (parity symbol 1 when parity is built in).
        push(8'h07);
        wait_idle(FRAME * 3, "byte07");
        check("byte07_busy_cycles", last_busy_run, FRAME + 2);

        // Randomized traffic with random gaps and en toggles.
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) == 0) en = 1'b0;
            repeat ($urandom_range(0, 120)) @(negedge clk);
            en = 1'b1;
            push(8'($urandom_range(0, 255)));
        end
        wait_idle(FRAME * 30, "random");

        check("total_pops", n_pops, n_pushed);
        check("frames_plus_aborted", frames_done + aborted, n_pushed);
        check("exp_queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
